// File: rtl/noc_test_node_pkg.sv
// Shared NoC constants: flit width, coordinate width, header field offsets,
// TX state encoding and the body-flit payload layout.
package noc_test_node_pkg;

    localparam int unsigned NOC_DATA_WIDTH = 32;
    localparam int unsigned COORD_W        = 4;
    localparam int unsigned SEQ_W          = 8;
    localparam int unsigned IDX_W          = 8;

    localparam int unsigned DEST_X_LSB = 0;
    localparam int unsigned DEST_Y_LSB = 4;
    localparam int unsigned SRC_X_LSB  = 8;
    localparam int unsigned SRC_Y_LSB  = 12;
    localparam int unsigned SEQ_LSB    = 16;

    typedef enum logic [1:0] {
        TX_GAPWAIT = 2'd0,
        TX_SEND    = 2'd1,
        TX_DONE    = 2'd2
    } tx_state_e;

    // Body/tail payload occupying flit bits [23:0]
    typedef struct packed {
        logic [COORD_W-1:0] src_y;
        logic [COORD_W-1:0] src_x;
        logic [SEQ_W-1:0]   seq;
        logic [IDX_W-1:0]   idx;
    } body_fields_t;

endpackage

// File: rtl/noc_test_node_rx.sv
// Ejection-side checker: always ready after reset, counts packets whose
// destination matches this node, saturating at 255.
module noc_test_node_rx
    import noc_test_node_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int unsigned X_ID       = 0,
    parameter int unsigned Y_ID       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  receive_valid,
    input  logic [DATA_WIDTH-1:0] receive_flit,
    input  logic                  receive_is_header,
    input  logic                  receive_is_tail,
    output logic                  receive_ready,
    output logic [7:0]            receive_num
);

    localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_ID);

    logic               ready_q;
    logic [7:0]         num_q;
    logic               pkt_open_q;
    logic [COORD_W-1:0] dest_x_q;
    logic [COORD_W-1:0] dest_y_q;

    logic               fire_c;
    logic [COORD_W-1:0] cur_x_c;
    logic [COORD_W-1:0] cur_y_c;
    logic [COORD_W-1:0] chk_x_c;
    logic [COORD_W-1:0] chk_y_c;
    logic               pkt_end_c;
    logic               hit_c;
    logic               unused_flit;

    assign fire_c  = receive_valid && ready_q;
    assign cur_x_c = receive_flit[DEST_X_LSB +: COORD_W];
    assign cur_y_c = receive_flit[DEST_Y_LSB +: COORD_W];

    // A single-flit packet is checked against its own header fields
    assign chk_x_c   = receive_is_header ? cur_x_c : dest_x_q;
    assign chk_y_c   = receive_is_header ? cur_y_c : dest_y_q;
    assign pkt_end_c = fire_c && receive_is_tail && (receive_is_header || pkt_open_q);
    assign hit_c     = pkt_end_c && (chk_x_c == MY_X) && (chk_y_c == MY_Y);

    assign unused_flit = ^receive_flit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            num_q      <= '0;
            pkt_open_q <= 1'b0;
            dest_x_q   <= '0;
            dest_y_q   <= '0;
        end else begin
            ready_q <= 1'b1;
            if (fire_c) begin
                if (receive_is_header) begin
                    dest_x_q   <= cur_x_c;
                    dest_y_q   <= cur_y_c;
                    pkt_open_q <= !receive_is_tail;
                end else if (receive_is_tail) begin
                    pkt_open_q <= 1'b0;
                end
            end
            if (hit_c && (num_q != 8'hFF)) begin
                num_q <= num_q + 8'd1;
            end
        end
    end

    assign receive_ready = ready_q;
    assign receive_num   = num_q;

endmodule

// File: rtl/noc_test_node.sv
// NoC leaf endpoint: injects NUM_PKTS wormhole packets of PKT_LEN flits to a
// fixed destination and counts packets ejected to this node.
module noc_test_node
    import noc_test_node_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int unsigned X_ID       = 0,
    parameter int unsigned Y_ID       = 0,
    parameter int unsigned DEST_X_ID  = 1,
    parameter int unsigned DEST_Y_ID  = 1,
    parameter int unsigned PKT_LEN    = 4,
    parameter int unsigned NUM_PKTS   = 16,
    parameter int unsigned GAP        = 2
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic                  receive_valid,
    output logic                  receive_ready,
    input  logic [DATA_WIDTH-1:0] receive_flit,
    input  logic                  receive_is_header,
    input  logic                  receive_is_tail,
    output logic                  sender_valid,
    input  logic                  sender_ready,
    output logic [DATA_WIDTH-1:0] sender_flit,
    output logic                  sender_is_header,
    output logic                  sender_is_tail,
    output logic [7:0]            receive_num
);

    localparam logic [COORD_W-1:0] MY_X   = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] MY_Y   = COORD_W'(Y_ID);
    localparam logic [COORD_W-1:0] DST_X  = COORD_W'(DEST_X_ID);
    localparam logic [COORD_W-1:0] DST_Y  = COORD_W'(DEST_Y_ID);
    localparam int unsigned        GAP_W  = (GAP < 2) ? 1 : $clog2(GAP);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(PKT_LEN - 1);

    function automatic logic [DATA_WIDTH-1:0] header_flit(input logic [SEQ_W-1:0] seq);
        logic [DATA_WIDTH-1:0] f;
        f = '0;
        f[DEST_X_LSB +: COORD_W] = DST_X;
        f[DEST_Y_LSB +: COORD_W] = DST_Y;
        f[SRC_X_LSB  +: COORD_W] = MY_X;
        f[SRC_Y_LSB  +: COORD_W] = MY_Y;
        f[SEQ_LSB    +: SEQ_W]   = seq;
        return f;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] body_flit(input logic [IDX_W-1:0] idx,
                                                        input logic [SEQ_W-1:0] seq);
        body_fields_t b;
        b = '{src_y: MY_Y, src_x: MY_X, seq: seq, idx: idx};
        return DATA_WIDTH'(b);
    endfunction

    tx_state_e             state_q, state_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] flit_q, flit_d;
    logic                  hdr_q, hdr_d;
    logic                  tail_q, tail_d;
    logic                  gap_done_c;

    assign gap_done_c = (GAP == 0) || (gap_q == GAP_W'(GAP - 1));

    // TX next-state and next-output logic; outputs are the registered copies
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        seq_d   = seq_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        flit_d  = flit_q;
        hdr_d   = hdr_q;
        tail_d  = tail_q;
        unique case (state_q)
            TX_GAPWAIT: begin
                if (gap_done_c) begin
                    gap_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    flit_d  = header_flit(seq_q);
                    hdr_d   = 1'b1;
                    tail_d  = (PKT_LEN == 1);
                    state_d = TX_SEND;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            TX_SEND: begin
                if (valid_q && sender_ready) begin
                    if (tail_q) begin
                        valid_d = 1'b0;
                        flit_d  = '0;
                        hdr_d   = 1'b0;
                        tail_d  = 1'b0;
                        if ((32'(seq_q) + 32'd1) < NUM_PKTS) begin
                            seq_d   = seq_q + SEQ_W'(1);
                            state_d = TX_GAPWAIT;
                        end else begin
                            state_d = TX_DONE;
                        end
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        flit_d = body_flit(idx_q + IDX_W'(1), seq_q);
                        hdr_d  = 1'b0;
                        tail_d = ((idx_q + IDX_W'(1)) == LAST_IDX);
                    end
                end
            end
            TX_DONE: begin
                valid_d = 1'b0;
                flit_d  = '0;
                hdr_d   = 1'b0;
                tail_d  = 1'b0;
            end
            default: begin
                state_d = TX_GAPWAIT;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            state_q <= TX_GAPWAIT;
            gap_q   <= '0;
            seq_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            flit_q  <= '0;
            hdr_q   <= 1'b0;
            tail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            flit_q  <= flit_d;
            hdr_q   <= hdr_d;
            tail_q  <= tail_d;
        end
    end

    assign sender_valid     = valid_q;
    assign sender_flit      = flit_q;
    assign sender_is_header = hdr_q;
    assign sender_is_tail   = tail_q;

    noc_test_node_rx #(
        .DATA_WIDTH (DATA_WIDTH),
        .X_ID       (X_ID),
        .Y_ID       (Y_ID)
    ) u_rx (
        .clk               (noc_clk),
        .rst_n             (noc_rst_n),
        .receive_valid     (receive_valid),
        .receive_flit      (receive_flit),
        .receive_is_header (receive_is_header),
        .receive_is_tail   (receive_is_tail),
        .receive_ready     (receive_ready),
        .receive_num       (receive_num)
    );

endmodule

// File: tb/tb_noc_test_node.sv
// Bench for noc_test_node: loopback traffic against a flit scoreboard, stalls,
// mid-packet reset, and directed ejection traffic for the receive counter.
module tb_noc_test_node;

    localparam int unsigned DW = 32;
    localparam int unsigned PL = 4;
    localparam int unsigned NP = 16;
    localparam int unsigned GP = 2;
    localparam logic [3:0]  NODE_X = 4'd0;
    localparam logic [3:0]  NODE_Y = 4'd0;

    typedef struct packed {
        logic [DW-1:0] flit;
        logic          hdr;
        logic          tail;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          loop_en;
    logic          tb_rv, tb_rh, tb_rt;
    logic [DW-1:0] tb_rf;
    logic          sender_ready;
    logic          sender_valid, sender_is_header, sender_is_tail, receive_ready;
    logic [DW-1:0] sender_flit;
    logic [7:0]    receive_num;
    logic          rv, rh, rt;
    logic [DW-1:0] rf;

    // Loopback presents only flits that actually handshake on the TX side
    assign rv = loop_en ? (sender_valid && sender_ready) : tb_rv;
    assign rf = loop_en ? sender_flit      : tb_rf;
    assign rh = loop_en ? sender_is_header : tb_rh;
    assign rt = loop_en ? sender_is_tail   : tb_rt;

    noc_test_node #(
        .DATA_WIDTH (DW),
        .X_ID       (0),
        .Y_ID       (0),
        .DEST_X_ID  (0),
        .DEST_Y_ID  (0),
        .PKT_LEN    (PL),
        .NUM_PKTS   (NP),
        .GAP        (GP)
    ) dut (
        .noc_clk           (clk),
        .noc_rst_n         (rst_n),
        .receive_valid     (rv),
        .receive_ready     (receive_ready),
        .receive_flit      (rf),
        .receive_is_header (rh),
        .receive_is_tail   (rt),
        .sender_valid      (sender_valid),
        .sender_ready      (sender_ready),
        .sender_flit       (sender_flit),
        .sender_is_header  (sender_is_header),
        .sender_is_tail    (sender_is_tail),
        .receive_num       (receive_num)
    );

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb[$];
    int   exp_num;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] exp_hdr(input int seq, input logic [3:0] dx, input logic [3:0] dy);
        logic [7:0] s;
        s = 8'(seq);
        return {8'h00, s, NODE_Y, NODE_X, dy, dx};
    endfunction

    function automatic logic [DW-1:0] exp_body(input int idx, input int seq);
        logic [7:0] s;
        logic [7:0] i;
        s = 8'(seq);
        i = 8'(idx);
        return {8'h00, NODE_Y, NODE_X, s, i};
    endfunction

    task automatic push_all();
        exp_t e;
        for (int p = 0; p < int'(NP); p++) begin
            for (int i = 0; i < int'(PL); i++) begin
                e.flit = (i == 0) ? exp_hdr(p, 4'd0, 4'd0) : exp_body(i, p);
                e.hdr  = (i == 0);
                e.tail = (i == int'(PL) - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(sender_valid), 64'd0);
        check({tag, "_flit"},  64'(sender_flit), 64'd0);
        check({tag, "_hdr"},   64'(sender_is_header), 64'd0);
        check({tag, "_tail"},  64'(sender_is_tail), 64'd0);
        check({tag, "_rready"}, 64'(receive_ready), 64'd0);
        check({tag, "_rnum"},  64'(receive_num), 64'd0);
    endtask

    task automatic wait_drain(input int budget, input logic toggle, input string tag);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(posedge clk);
            #1;
            if (toggle) sender_ready = ~sender_ready;
            c++;
        end
        check(tag, 64'(sb.size()), 64'd0);
        sender_ready = 1'b1;
    endtask

    task automatic rx_flit(input logic [DW-1:0] f, input logic h, input logic t);
        tb_rv = 1'b1;
        tb_rf = f;
        tb_rh = h;
        tb_rt = t;
        @(posedge clk);
        #1;
        tb_rv = 1'b0;
        tb_rf = '0;
        tb_rh = 1'b0;
        tb_rt = 1'b0;
    endtask

    task automatic rx_pkt(input logic [3:0] dx, input logic [3:0] dy, input int len,
                          input logic with_hdr, input logic idle_between, input string tag);
        logic h, t;
        for (int i = 0; i < len; i++) begin
            h = with_hdr && (i == 0);
            t = (i == len - 1);
            rx_flit(h ? exp_hdr(7, dx, dy) : exp_body(i, 7), h, t);
            if (idle_between) begin
                @(posedge clk);
                #1;
            end
        end
        if (with_hdr && dx == NODE_X && dy == NODE_Y && exp_num < 255) exp_num++;
        check(tag, 64'(receive_num), 64'(exp_num));
    endtask

    // TX monitor: scoreboard pop on handshake, stall stability, bubbles, gap length
    logic          prev_v, prev_r, prev_h, prev_t, prev_hs, prev_hs_tail, after_tail;
    logic [DW-1:0] prev_f;
    int            idle, hs_cnt;
    exp_t          got;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0; prev_r = 1'b0; prev_h = 1'b0; prev_t = 1'b0; prev_f = '0;
            prev_hs = 1'b0; prev_hs_tail = 1'b0; after_tail = 1'b0;
            idle = 0; hs_cnt = 0;
        end else begin
            if (prev_v && !prev_r)
                check("stall_hold", 64'({sender_valid, sender_is_header, sender_is_tail, sender_flit}),
                      64'({1'b1, prev_h, prev_t, prev_f}));
            if (prev_hs && !prev_hs_tail)
                check("no_bubble", 64'(sender_valid), 64'd1);
            if (after_tail && sender_valid) begin
                check("gap_len", 64'(idle), 64'(GP));
                after_tail = 1'b0;
            end else if (after_tail) begin
                idle++;
            end
            prev_hs      = sender_valid && sender_ready;
            prev_hs_tail = sender_is_tail;
            if (sender_valid && sender_ready) begin
                hs_cnt++;
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    got = sb.pop_front();
                    check("tx_flit", 64'({sender_is_header, sender_is_tail, sender_flit}),
                          64'({got.hdr, got.tail, got.flit}));
                end
                if (sender_is_tail) begin
                    after_tail = 1'b1;
                    idle = 0;
                end
            end
            prev_v = sender_valid; prev_r = sender_ready; prev_h = sender_is_header;
            prev_t = sender_is_tail; prev_f = sender_flit;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n = 1'b0; loop_en = 1'b1; sender_ready = 1'b1;
        tb_rv = 1'b0; tb_rf = '0; tb_rh = 1'b0; tb_rt = 1'b0;
        exp_num = 0;

        // Loopback, ready held high
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst1");
        push_all();
        rst_n = 1'b1;
        wait_drain(2000, 1'b0, "drain_full_rate");
        repeat (5) @(posedge clk);
        #1;
        check("loop_rnum", 64'(receive_num), 64'd16);
        check("loop_rready", 64'(receive_ready), 64'd1);
        check("done_valid", 64'(sender_valid), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        check("done_valid_hold", 64'(sender_valid), 64'd0);

        // Loopback with ready toggling every cycle
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst2");
        push_all();
        rst_n = 1'b1;
        sender_ready = 1'b0;
        wait_drain(4000, 1'b1, "drain_toggle");
        repeat (5) @(posedge clk);
        #1;
        check("toggle_rnum", 64'(receive_num), 64'd16);
        check("toggle_done", 64'(sender_valid), 64'd0);

        // Reset after flit 2 of packet 3, then a clean full run
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        push_all();
        rst_n = 1'b1;
        c = 0;
        while (hs_cnt < 3 * int'(PL) + 3 && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("mid_reached", 64'(hs_cnt >= 3 * int'(PL) + 3), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        sb.delete();
        push_all();
        rst_n = 1'b1;
        wait_drain(2000, 1'b0, "drain_after_abort");
        repeat (5) @(posedge clk);
        #1;
        check("abort_rnum", 64'(receive_num), 64'd16);

        // Directed ejection traffic; TX stalls on its first header meanwhile
        rst_n = 1'b0;
        loop_en = 1'b0;
        sender_ready = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rx_ready_first", 64'(receive_ready), 64'd1);
        exp_num = 0;
        rx_pkt(4'd1, 4'd0, 4, 1'b1, 1'b0, "rx_wrong_x");
        rx_pkt(4'd0, 4'd0, 4, 1'b1, 1'b0, "rx_own_4");
        rx_pkt(4'd0, 4'd0, 1, 1'b1, 1'b0, "rx_own_single");
        rx_pkt(4'd0, 4'd0, 3, 1'b0, 1'b0, "rx_headerless");
        rx_pkt(4'd0, 4'd1, 1, 1'b1, 1'b0, "rx_wrong_y_single");
        rx_pkt(4'd1, 4'd1, 2, 1'b1, 1'b0, "rx_wrong_xy");
        rx_pkt(4'd0, 4'd0, 3, 1'b1, 1'b1, "rx_own_idle");
        for (int k = 0; k < 300; k++) rx_pkt(4'd0, 4'd0, 1, 1'b1, 1'b0, "rx_sat");
        check("rx_saturated", 64'(receive_num), 64'd255);
        check("tx_held_header", 64'({sender_valid, sender_is_header, sender_flit}),
              64'({1'b1, 1'b1, exp_hdr(0, 4'd0, 4'd0)}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
